// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 4-lane TDM demultiplexer.
package tdm_demux_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned SLOT_W = 2;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  function automatic logic [LANES-1:0] lane_onehot(input logic [SLOT_W-1:0] idx);
    logic [LANES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tdm_frame_tracker.sv
// Frame-sync tracker: hunts for fsync, walks the slot counter and flags sync faults.
module tdm_frame_tracker
  import tdm_demux_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ena,
  input  logic              i_fsync,
  input  logic              i_manual,
  output logic              o_we,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_frame_valid,
  output logic              o_locked,
  output logic              o_sync_err
);

  state_e            r_state, w_state_d;
  logic [SLOT_W-1:0] r_slot, w_slot_d;
  logic              r_ok, w_ok_d;
  logic              r_fv, w_fv_d;
  logic              r_err, w_err_d;

  always_comb begin
    w_state_d = r_state;
    w_slot_d  = r_slot;
    w_ok_d    = r_ok;
    w_fv_d    = 1'b0;
    w_err_d   = r_err;
    o_we      = 1'b0;
    o_slot    = '0;
    if (i_manual) begin
      w_state_d = HUNT;
      w_slot_d  = '0;
      w_ok_d    = 1'b0;
    end else if (i_ena) begin
      case (r_state)
        HUNT: begin
          if (i_fsync) begin
            o_we      = 1'b1;
            w_slot_d  = SLOT_W'(1);
            w_state_d = LOCKED;
            w_ok_d    = 1'b1;
          end
        end
        LOCKED: begin
          if (i_fsync) begin
            // An early sync realigns to slot 0; that frame is not reported as valid.
            o_we     = 1'b1;
            w_slot_d = SLOT_W'(1);
            if (r_slot != '0) begin
              w_err_d = 1'b1;
              w_ok_d  = 1'b0;
            end else begin
              w_ok_d  = 1'b1;
            end
          end else if (r_slot == '0) begin
            w_err_d   = 1'b1;
            w_state_d = HUNT;
          end else begin
            o_we     = 1'b1;
            o_slot   = r_slot;
            w_slot_d = r_slot + SLOT_W'(1);
            w_fv_d   = (r_slot == SLOT_W'(LANES - 1)) && r_ok;
          end
        end
        default: w_state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= HUNT;
      r_slot  <= '0;
      r_ok    <= 1'b0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_slot  <= w_slot_d;
      r_ok    <= w_ok_d;
      r_fv    <= w_fv_d;
      r_err   <= w_err_d;
    end
  end

  assign o_frame_valid = r_fv;
  assign o_locked      = (r_state == LOCKED);
  assign o_sync_err    = r_err;

endmodule

// File: rtl/tdm_demux4.sv
// 4-lane TDM demultiplexer: stream mode follows the frame tracker, manual mode routes by sel.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [W-1:0]        din,
  input  logic                fsync,
  input  logic                manual,
  input  logic [SLOT_W-1:0]   sel,
  output logic [LANES*W-1:0]  lane_out,
  output logic [LANES-1:0]    lane_upd,
  output logic                frame_valid,
  output logic                locked,
  output logic                sync_err
);

  logic                      w_trk_we;
  logic [SLOT_W-1:0]         w_trk_slot;
  logic                      w_we;
  logic [SLOT_W-1:0]         w_idx;
  logic [LANES-1:0][W-1:0]   r_lane;
  logic [LANES-1:0]          r_upd;

  tdm_frame_tracker u_tracker (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ena         (ena),
    .i_fsync       (fsync),
    .i_manual      (manual),
    .o_we          (w_trk_we),
    .o_slot        (w_trk_slot),
    .o_frame_valid (frame_valid),
    .o_locked      (locked),
    .o_sync_err    (sync_err)
  );

  assign w_we  = manual ? ena : w_trk_we;
  assign w_idx = manual ? sel : w_trk_slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lane <= '0;
      r_upd  <= '0;
    end else begin
      r_upd <= w_we ? lane_onehot(w_idx) : '0;
      if (w_we) begin
        r_lane[w_idx] <= din;
      end
    end
  end

  assign lane_out = r_lane;
  assign lane_upd = r_upd;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus a randomized run vs a slot model.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic [0:0] din = '0;
  logic       fsync = 1'b0;
  logic       manual = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] lane_out;
  logic [3:0] lane_upd;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [3:0] m_lane;
  logic [3:0] m_upd;
  logic       m_fv;
  logic       m_err;
  logic       m_hunt;
  int         m_slot;
  logic       m_aligned;

  tdm_demux4 #(.W(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .din         (din),
    .fsync       (fsync),
    .manual      (manual),
    .sel         (sel),
    .lane_out    (lane_out),
    .lane_upd    (lane_upd),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  // Applies the behavioural rules to the inputs about to be sampled.
  task automatic model_edge();
    if (rst) begin
      m_lane = '0; m_upd = '0; m_fv = 1'b0; m_err = 1'b0;
      m_hunt = 1'b1; m_slot = 0; m_aligned = 1'b0;
    end else begin
      m_upd = '0;
      m_fv  = 1'b0;
      if (manual) begin
        m_hunt = 1'b1; m_slot = 0; m_aligned = 1'b0;
        if (ena) begin
          m_lane[sel] = din[0];
          m_upd[sel]  = 1'b1;
        end
      end else if (ena) begin
        if (m_hunt) begin
          if (fsync) begin
            m_lane[0] = din[0]; m_upd[0] = 1'b1;
            m_slot = 1; m_hunt = 1'b0; m_aligned = 1'b1;
          end
        end else if (fsync) begin
          if (m_slot != 0) begin
            m_err = 1'b1; m_aligned = 1'b0;
          end else begin
            m_aligned = 1'b1;
          end
          m_lane[0] = din[0]; m_upd[0] = 1'b1; m_slot = 1;
        end else if (m_slot == 0) begin
          m_err = 1'b1; m_hunt = 1'b1;
        end else begin
          m_lane[m_slot] = din[0]; m_upd[m_slot] = 1'b1;
          if (m_slot == 3 && m_aligned) m_fv = 1'b1;
          m_slot = (m_slot + 1) % 4;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic f, input logic d);
    ena = e; fsync = f; din = d;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; ena = 1'b0; fsync = 1'b0; manual = 1'b0; din = '0; sel = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; manual = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = 1'($urandom); fsync = 1'($urandom);
      step();
    end
    n_cmp++;
    if ({lane_out, lane_upd, frame_valid, locked, sync_err} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%b upd=%b fv=%b lk=%b err=%b, want all 0",
               lane_out, lane_upd, frame_valid, locked, sync_err);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'($urandom));
      n_cmp++;
      if (lane_upd !== 4'b0 || lane_out !== 4'b0 || locked !== 1'b0) begin
        n_fail++;
        $display("FAIL hunt_no_write[%0d]: got out=%b upd=%b lk=%b, want 0/0/0",
                 i, lane_out, lane_upd, locked);
      end
    end
  endtask

  task automatic test_locked_frame();
    do_reset();
    drive(1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL lock_rise: got %b want 1", locked);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (lane_out !== 4'b1101 || frame_valid !== 1'b1 || lane_upd !== 4'b1000) begin
      n_fail++;
      $display("FAIL frame1: got out=%b fv=%b upd=%b want 1101/1/1000",
               lane_out, frame_valid, lane_upd);
    end
    drive(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL fv_one_cycle: got %b want 0", frame_valid);
    end
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (lane_out !== 4'b0110 || frame_valid !== 1'b1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL frame2: got out=%b fv=%b lk=%b want 0110/1/1", lane_out, frame_valid, locked);
    end
  endtask

  task automatic test_early_sync();
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);  // fsync arriving at slot 2
    n_cmp++;
    if (sync_err !== 1'b1 || lane_upd !== 4'b0001 || lane_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL early_sync: got err=%b upd=%b lane0=%b want 1/0001/1",
               sync_err, lane_upd, lane_out[0]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (frame_valid !== 1'b0) begin
        n_fail++; $display("FAIL realigned_no_fv[%0d]: got %b want 0", i, frame_valid);
      end
    end
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b1 || sync_err !== 1'b1 || lane_out !== 4'b1001) begin
      n_fail++;
      $display("FAIL after_early: got fv=%b err=%b out=%b want 1/1/1001",
               frame_valid, sync_err, lane_out);
    end
  endtask

  task automatic test_missing_sync();
    do_reset();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);  // slot 0 without fsync
    n_cmp++;
    if (locked !== 1'b0 || sync_err !== 1'b1 || lane_out !== 4'b1001 || lane_upd !== 4'b0) begin
      n_fail++;
      $display("FAIL missing_sync: got lk=%b err=%b out=%b upd=%b want 0/1/1001/0000",
               locked, sync_err, lane_out, lane_upd);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'($urandom));
      n_cmp++;
      if (lane_out !== 4'b1001 || lane_upd !== 4'b0) begin
        n_fail++;
        $display("FAIL hold_unlocked[%0d]: got out=%b upd=%b want 1001/0000", i, lane_out, lane_upd);
      end
    end
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (locked !== 1'b1 || lane_out !== 4'b0110 || frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL relock: got lk=%b out=%b fv=%b want 1/0110/1", locked, lane_out, frame_valid);
    end
  endtask

  task automatic test_manual();
    do_reset();
    manual = 1'b1; sel = 2'd2;
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (lane_out !== 4'b0100 || lane_upd !== 4'b0100 || locked !== 1'b0 || frame_valid !== 1'b0)
    begin
      n_fail++;
      $display("FAIL manual_write: got out=%b upd=%b lk=%b fv=%b want 0100/0100/0/0",
               lane_out, lane_upd, locked, frame_valid);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (lane_upd !== 4'b0 || lane_out !== 4'b0100) begin
      n_fail++; $display("FAIL manual_pulse: got upd=%b out=%b want 0000/0100", lane_upd, lane_out);
    end
    manual = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    manual = 1'b1; sel = 2'd3;
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (locked !== 1'b0 || lane_out !== 4'b1111 || lane_upd !== 4'b1000) begin
      n_fail++;
      $display("FAIL manual_unlock: got lk=%b out=%b upd=%b want 0/1111/1000",
               locked, lane_out, lane_upd);
    end
    manual = 1'b0;
  endtask

  task automatic test_ena_gap();
    do_reset();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'($urandom));
      n_cmp++;
      if (lane_upd !== 4'b0 || frame_valid !== 1'b0 || locked !== 1'b1) begin
        n_fail++;
        $display("FAIL ena_gap[%0d]: got upd=%b fv=%b lk=%b want 0000/0/1",
                 i, lane_upd, frame_valid, locked);
      end
    end
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (lane_upd !== 4'b0100) begin
      n_fail++; $display("FAIL gap_resume: got upd=%b want 0100", lane_upd);
    end
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b1 || lane_out !== 4'b1101) begin
      n_fail++; $display("FAIL gap_frame: got fv=%b out=%b want 1/1101", frame_valid, lane_out);
    end
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    n_cmp++;
    if ({lane_out, lane_upd, frame_valid, locked, sync_err} !== 11'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got out=%b upd=%b fv=%b lk=%b err=%b want all 0",
               lane_out, lane_upd, frame_valid, locked, sync_err);
    end
  endtask

  task automatic test_random();
    int pos;
    do_reset();
    pos = 0;
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      manual = ($urandom_range(0, 19) == 0);
      sel    = 2'($urandom);
      ena    = ($urandom_range(0, 4) != 0);
      din    = 1'($urandom);
      fsync  = ((pos % 4) == 0) ^ ($urandom_range(0, 24) == 0);
      if (ena && !manual) pos++;
      step();
      n_cmp++;
      if (lane_out !== m_lane || lane_upd !== m_upd || frame_valid !== m_fv ||
          locked !== !m_hunt || sync_err !== m_err) begin
        n_fail++;
        $display("FAIL random[%0d]: got out=%b upd=%b fv=%b lk=%b err=%b want %b/%b/%b/%b/%b",
                 i, lane_out, lane_upd, frame_valid, locked, sync_err,
                 m_lane, m_upd, m_fv, !m_hunt, m_err);
      end
    end
    rst = 1'b0; manual = 1'b0;
  endtask

  initial begin
    test_reset();
    test_locked_frame();
    test_early_sync();
    test_missing_sync();
    test_manual();
    test_ena_gap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer: the receive-side counterpart of our 4:1 lane mux. It takes a time-multiplexed sample stream, 4 slots per frame with slot 0 marked by a frame-sync strobe, and distributes each slot into one of four held lane registers. A manual mode routes the input to a lane chosen by an explicit 2-bit select, which is the direct inverse of the mux. The block sits behind the input pins in the user project and feeds per-lane logic or output pins.

## Interface
- W, 1, sample width per slot
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  sample enable; when low, nothing is sampled or advanced
- din  in  W  stream sample, valid on cycles with ena=1
- fsync  in  1  marks the din sample as slot 0 (stream mode only)
- manual  in  1  1 = manual routing via sel; 0 = stream mode
- sel  in  2  target lane in manual mode
- lane_out  out  4*W  held lane values; lane i = lane_out[i*W +: W]
- lane_upd  out  4  one-cycle pulse per lane written
- frame_valid  out  1  one-cycle pulse when a sync-aligned frame completes
- locked  out  1  frame tracker in LOCKED
- sync_err  out  1  sticky sync error flag, cleared only by rst

## Operation
- The clock is clk. The reset is synchronous and active-high (rst). The port is named rst, not rst_n.
- Reset values: lane_out=0, lane_upd=0, frame_valid=0, locked=0, sync_err=0, state=HUNT, slot=0.
- FSM states:
  - HUNT: ignore din until ena & fsync. On that cycle write din to lane 0, set slot=1, go to LOCKED.
  - LOCKED: on each ena cycle write din to lane[slot], then slot = slot+1 mod 4.
  - fsync at slot 0: normal.
  - fsync at slot≠0 (early sync): set sync_err. Write din to lane 0 and set slot=1. The partial frame gives no frame_valid.
  - No fsync at slot 0 (missing sync): set sync_err, write nothing, go to HUNT, locked drops.
- frame_valid pulses on the write of slot 3 only if slot 0 of that frame was written with fsync and the frame had no realign.
- manual=1: on each ena cycle write din to lane[sel] and pulse lane_upd[sel]. The FSM is forced to HUNT with slot=0 and frame_valid=0. sync_err is not modified.
- Switching manual from 1 to 0 resumes in HUNT.
- ena=0: no writes, slot/state hold, lane_upd and frame_valid are 0 on the next cycle. ena gaps mid-frame are legal and do not break lock.
- Unwritten lanes always hold their previous values.
- rst mid-frame: everything returns to reset values on that edge, including lane data.

## Timing
- A sample accepted at edge k is visible on lane_out after edge k (1-cycle latency).
- lane_upd and frame_valid are registered and asserted in the same cycle the new lane value first appears.
- frame_valid coincides with lane_upd[3].
- locked rises the cycle after the accepting fsync edge and falls the cycle after a missing-sync edge.
- sync_err rises the cycle after the faulty edge.
- Back-to-back frames at full rate: frame_valid every 4 cycles.

## Structure
- Package tdm_demux_pkg holds:
  - LANES=4
  - SLOT_W=2
  - the state enum {HUNT, LOCKED}
- Sub-module tdm_frame_tracker holds the FSM, the slot counter, and the sync_err/locked/frame_valid generation. It outputs a write-enable and a lane index.
- The top level holds the manual/stream index select and the lane register bank.

## Test plan
- Reset: hold rst 2 cycles with random din/fsync. Expect all outputs 0 and locked=0. Keep rst low with fsync=0 for 10 cycles: still no writes.
- Locked frame (W=1, ena=1): fsync with din on cycles 0..3 = 1,0,1,1. After edge 3 expect lane_out=4'b1101, frame_valid high exactly 1 cycle, locked=1. A second frame 0,1,1,0 gives lane_out=4'b0110 and frame_valid 4 cycles later.
- Early fsync at slot 2 with din=1: expect sync_err=1, lane_upd=4'b0001, lane_out[0]=1. No frame_valid for the broken frame. The next full frame gives frame_valid.
- Missing fsync at slot 0: expect locked→0, sync_err=1, lane_out unchanged until the next fsync, then relock.
- Manual mode: manual=1, sel=2, din=1 from lane_out=0. Expect lane_out=4'b0100, lane_upd=4'b0100 for 1 cycle, locked=0, frame_valid=0.
- ena=0 for 3 cycles after slot 1 of a frame: no lane_upd, slot holds. On resume, slots 2,3 complete with frame_valid. Then rst asserted mid-frame: all outputs 0 next cycle.
